// File: rtl/arp_pkg.sv
// Shared types and constants for the IP-to-MAC resolution cache.
// Pure declarations: no logic, no latency, no flow control.
// Imported by arp_cache and arp_cache_match.
package arp_pkg;

  localparam logic [47:0] MAC_BCAST    = 48'hFFFF_FFFF_FFFF;
  localparam logic        ARP_OP_REQ   = 1'b0;
  localparam logic        ARP_OP_REPLY = 1'b1;

  typedef struct packed {
    logic        vld;
    logic [31:0] ip;
    logic [47:0] mac;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lkp_state_t;

endpackage

// File: rtl/arp_cache_match.sv
// Parallel IP comparator over all cache entries; reports lowest matching and lowest free index.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module arp_cache_match
  import arp_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW   = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0] tbl,
  input  logic [31:0]        ip,
  output logic               hit,
  output logic [IW-1:0]      hit_idx,
  output logic               free_vld,
  output logic [IW-1:0]      free_idx
);

  // Walk from the top so the lowest index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tbl[i].vld && (tbl[i].ip == ip)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!tbl[i].vld) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/arp_cache.sv
// DEPTH-entry IP-to-MAC cache: learns every ARP receive, resolves lookups, issues ARP requests on a miss.
// Latency: hit -> lkp_done 2 cycles after accept; miss -> up to REQ_RETRY request/timeout rounds.
// Backpressure: lkp_rdy low while a lookup is in flight; requests stall on arp_tx_rdy. Aging: ARP_CACHE_AGING_EN.
module arp_cache
  import arp_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int REQ_TIMEOUT = 125_000_000,
  parameter int REQ_RETRY   = 3
`ifdef ARP_CACHE_AGING_EN
  ,
  parameter int TICK_DIV    = 125_000_000,
  parameter int AGE_MAX     = 300
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        flush,
  input  logic        lkp_req,
  input  logic [31:0] lkp_ip,
  output logic        lkp_rdy,
  output logic        lkp_done,
  output logic        lkp_hit,
  output logic [47:0] lkp_mac,
  input  logic        arp_tx_rdy,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip
);

  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam int RW = $clog2(REQ_RETRY + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(REQ_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(REQ_RETRY);

  entry_t [DEPTH-1:0] tbl;
  logic [IW-1:0]      rr_ptr;

  logic          ln_hit, ln_free_vld, learn_en;
  logic [IW-1:0] ln_hit_idx, ln_free_idx, learn_idx;
  logic          lk_hit;
  logic [IW-1:0] lk_hit_idx;
  logic          unused_lk_free_vld;
  logic [IW-1:0] unused_lk_free_idx;
  logic          unused_rx_type;

  lkp_state_t    state, state_nxt;
  logic [31:0]   lkp_ip_q, ip_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          done_nxt, hit_nxt, tx_en_nxt, req_active;
  logic [47:0]   mac_nxt;

  // Requests and replies are learned alike; the opcode carries no information here.
  assign unused_rx_type = (arp_rx_type == ARP_OP_REPLY);
  assign arp_tx_type    = ARP_OP_REQ;
  assign learn_en       = arp_rx_done && (src_ip != '0);
  assign learn_idx      = ln_hit ? ln_hit_idx : (ln_free_vld ? ln_free_idx : rr_ptr);

  arp_cache_match #(.DEPTH(DEPTH)) u_match_learn (
    .tbl      (tbl),
    .ip       (src_ip),
    .hit      (ln_hit),
    .hit_idx  (ln_hit_idx),
    .free_vld (ln_free_vld),
    .free_idx (ln_free_idx)
  );

  arp_cache_match #(.DEPTH(DEPTH)) u_match_lkp (
    .tbl      (tbl),
    .ip       (lkp_ip_q),
    .hit      (lk_hit),
    .hit_idx  (lk_hit_idx),
    .free_vld (unused_lk_free_vld),
    .free_idx (unused_lk_free_idx)
  );

`ifdef ARP_CACHE_AGING_EN
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(AGE_MAX + 1);
  logic [PW-1:0] pre;
  logic [AW-1:0] age [DEPTH];
  logic          tick;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) pre <= '0;
    else             pre <= pre + PW'(1);
  end
`endif

  // Table update; the learn is written last so it overrides a same-cycle aging expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      rr_ptr <= '0;
`ifdef ARP_CACHE_AGING_EN
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) tbl[i].vld <= 1'b0;
`ifdef ARP_CACHE_AGING_EN
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
    end else begin
`ifdef ARP_CACHE_AGING_EN
      if (tick) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (tbl[i].vld) begin
            if (age[i] == AW'(AGE_MAX - 1)) begin
              tbl[i].vld <= 1'b0;
              age[i]     <= '0;
            end else begin
              age[i] <= age[i] + AW'(1);
            end
          end
        end
      end
`endif
      if (learn_en) begin
        tbl[learn_idx] <= '{vld: 1'b1, ip: src_ip, mac: src_mac};
`ifdef ARP_CACHE_AGING_EN
        age[learn_idx] <= '0;
`endif
        if (!ln_hit && !ln_free_vld) rr_ptr <= rr_ptr + IW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ip_nxt    = lkp_ip_q;
    retry_nxt = retry;
    timer_nxt = timer;
    done_nxt  = 1'b0;
    tx_en_nxt = 1'b0;
    hit_nxt   = lkp_hit;
    mac_nxt   = lkp_mac;
    case (state)
      ST_IDLE: begin
        hit_nxt = 1'b0;
        mac_nxt = '0;
        if (lkp_req) begin
          ip_nxt    = lkp_ip;
          state_nxt = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (lk_hit) begin
          state_nxt = ST_DONE;
          hit_nxt   = 1'b1;
          mac_nxt   = tbl[lk_hit_idx].mac;
        end else begin
          state_nxt = ST_REQ;
          retry_nxt = '0;
        end
      end
      ST_REQ: begin
        if (arp_tx_rdy) begin
          tx_en_nxt = 1'b1;
          state_nxt = ST_WAIT;
          timer_nxt = '0;
          retry_nxt = retry + RW'(1);
        end
      end
      ST_WAIT: begin
        if (lk_hit) begin
          state_nxt = ST_DONE;
          hit_nxt   = 1'b1;
          mac_nxt   = tbl[lk_hit_idx].mac;
        end else if (timer == TMO_LAST) begin
          if (retry < RETRY_MAX) begin
            state_nxt = ST_REQ;
          end else begin
            state_nxt = ST_DONE;
            hit_nxt   = 1'b0;
            mac_nxt   = '0;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_active = (state_nxt == ST_REQ) || (state_nxt == ST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lkp_ip_q  <= '0;
      retry     <= '0;
      timer     <= '0;
      lkp_rdy   <= 1'b1;
      lkp_done  <= 1'b0;
      lkp_hit   <= 1'b0;
      lkp_mac   <= '0;
      arp_tx_en <= 1'b0;
      des_mac   <= '0;
      des_ip    <= '0;
    end else begin
      state     <= state_nxt;
      lkp_ip_q  <= ip_nxt;
      retry     <= retry_nxt;
      timer     <= timer_nxt;
      lkp_rdy   <= (state_nxt == ST_IDLE);
      lkp_done  <= done_nxt;
      lkp_hit   <= hit_nxt;
      lkp_mac   <= mac_nxt;
      arp_tx_en <= tx_en_nxt;
      des_mac   <= req_active ? MAC_BCAST : '0;
      des_ip    <= req_active ? ip_nxt : '0;
    end
  end

endmodule

// File: tb/tb_arp_cache.sv
// Bench for arp_cache: reset values, directed table of learn/lookup/flush vectors, reply and reset
// corner cases, and a randomized phase scored against a simple array model of the cache.
module tb_arp_cache;
  import arp_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;
  localparam int RETRY = 3;
  localparam int OP_LEARN = 0, OP_LOOKUP = 1, OP_FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_rx_done = 1'b0, arp_rx_type = 1'b0;
  logic [47:0] src_mac = '0;
  logic [31:0] src_ip = '0;
  logic        flush = 1'b0, lkp_req = 1'b0;
  logic [31:0] lkp_ip = '0;
  logic        lkp_rdy, lkp_done, lkp_hit;
  logic [47:0] lkp_mac;
  logic        arp_tx_rdy = 1'b1;
  logic        arp_tx_en, arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;

  always #4 clk = ~clk;

  arp_cache #(
    .DEPTH(DEPTH), .REQ_TIMEOUT(TMO), .REQ_RETRY(RETRY)
`ifdef ARP_CACHE_AGING_EN
    , .TICK_DIV(10), .AGE_MAX(3)
`endif
  ) dut (
    .clk(clk), .rst(rst), .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip), .flush(flush), .lkp_req(lkp_req), .lkp_ip(lkp_ip),
    .lkp_rdy(lkp_rdy), .lkp_done(lkp_done), .lkp_hit(lkp_hit), .lkp_mac(lkp_mac),
    .arp_tx_rdy(arp_tx_rdy), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
    .des_mac(des_mac), .des_ip(des_ip)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          op;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        typ;
    logic        exp_hit;
    logic [47:0] exp_mac;
    int          exp_tx;
  } vec_t;
  vec_t vt[18];

  logic        m_vld[DEPTH];
  logic [31:0] m_ip[DEPTH];
  logic [47:0] m_mac[DEPTH];
  int          m_rr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] mac, input logic typ);
    arp_rx_done = 1'b1; arp_rx_type = typ; src_ip = ip; src_mac = mac;
    step();
    arp_rx_done = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Issue one lookup; optionally answer the first ARP request reply_at cycles after it.
  task automatic do_lookup(input logic [31:0] ip, input int reply_at, input logic [47:0] rmac,
                           output logic hit, output logic [47:0] mac, output int ntx, output int lat);
    int  cyc, since;
    bit  done;
    ntx = 0; lat = 0; hit = 1'b0; mac = '0; done = 1'b0; since = -1; cyc = 0;
    chk("rdy_before_req", 64'(lkp_rdy), 64'(1));
    lkp_req = 1'b1; lkp_ip = ip;
    step();
    lkp_req = 1'b0; lkp_ip = $urandom();
    while (!done && cyc < 3000) begin
      arp_rx_done = 1'b0;
      lkp_req = (cyc == 1);
      if (since >= 0) begin
        since++;
        if (since == reply_at) begin
          arp_rx_done = 1'b1; arp_rx_type = ARP_OP_REPLY; src_ip = ip; src_mac = rmac;
        end
      end
      step();
      cyc++;
      if (arp_tx_en) begin
        ntx++;
        chk("tx_des_mac", 64'(des_mac), 64'(MAC_BCAST));
        chk("tx_des_ip", 64'(des_ip), 64'(ip));
        chk("tx_type", 64'(arp_tx_type), 64'(ARP_OP_REQ));
        if (since < 0 && reply_at >= 0) since = 0;
      end
      if (lkp_done) begin
        done = 1'b1; hit = lkp_hit; mac = lkp_mac; lat = cyc;
      end
    end
    arp_rx_done = 1'b0; lkp_req = 1'b0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL lookup_timeout: no lkp_done for ip %h within 3000 cycles", ip);
    end
    step();
    chk("done_one_cycle", 64'(lkp_done), 64'(0));
    chk("rdy_after_done", 64'(lkp_rdy), 64'(1));
  endtask

  function automatic void m_learn(input logic [31:0] ip, input logic [47:0] mac);
    int idx = -1;
    if (ip == '0) return;
    for (int i = 0; i < DEPTH; i++) if (idx < 0 && m_vld[i] && m_ip[i] == ip) idx = i;
    for (int i = 0; i < DEPTH; i++) if (idx < 0 && !m_vld[i]) idx = i;
    if (idx < 0) begin
      idx  = m_rr;
      m_rr = (m_rr + 1) % DEPTH;
    end
    m_vld[idx] = 1'b1; m_ip[idx] = ip; m_mac[idx] = mac;
  endfunction

  function automatic void m_lookup(input logic [31:0] ip, output logic hit, output logic [47:0] mac);
    hit = 1'b0; mac = '0;
    for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_ip[i] == ip) begin hit = 1'b1; mac = m_mac[i]; end
  endfunction

  initial begin
    logic        h, eh;
    logic [47:0] m, em, rmac;
    logic [31:0] rip;
    int          ntx, lat, nd, ra, etx;

    vt[0]  = '{OP_LEARN,  32'hC0A80117, 48'h2345_6789_0ABC, 1'b1, 1'b0, 48'h0, 0};
    vt[1]  = '{OP_LOOKUP, 32'hC0A80117, 48'h0,              1'b0, 1'b1, 48'h2345_6789_0ABC, 0};
    vt[2]  = '{OP_LEARN,  32'hC0A80102, 48'h0000_0000_0002, 1'b0, 1'b0, 48'h0, 0};
    vt[3]  = '{OP_LEARN,  32'hC0A80103, 48'h0000_0000_0003, 1'b1, 1'b0, 48'h0, 0};
    vt[4]  = '{OP_LEARN,  32'hC0A80104, 48'h0000_0000_0004, 1'b0, 1'b0, 48'h0, 0};
    vt[5]  = '{OP_LEARN,  32'hC0A80105, 48'h0000_0000_0005, 1'b1, 1'b0, 48'h0, 0};
    vt[6]  = '{OP_LOOKUP, 32'hC0A80117, 48'h0,              1'b0, 1'b0, 48'h0, RETRY};
    vt[7]  = '{OP_LOOKUP, 32'hC0A80105, 48'h0,              1'b0, 1'b1, 48'h0000_0000_0005, 0};
    vt[8]  = '{OP_LEARN,  32'hC0A80103, 48'h0200_0000_0001, 1'b1, 1'b0, 48'h0, 0};
    vt[9]  = '{OP_LOOKUP, 32'hC0A80103, 48'h0,              1'b0, 1'b1, 48'h0200_0000_0001, 0};
    vt[10] = '{OP_LEARN,  32'hC0A80106, 48'h0000_0000_0006, 1'b0, 1'b0, 48'h0, 0};
    vt[11] = '{OP_LOOKUP, 32'hC0A80102, 48'h0,              1'b0, 1'b0, 48'h0, RETRY};
    vt[12] = '{OP_LOOKUP, 32'hC0A80104, 48'h0,              1'b0, 1'b1, 48'h0000_0000_0004, 0};
    vt[13] = '{OP_LEARN,  32'h00000000, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 48'h0, 0};
    vt[14] = '{OP_LOOKUP, 32'h00000000, 48'h0,              1'b0, 1'b0, 48'h0, RETRY};
    vt[15] = '{OP_LOOKUP, 32'hC0A80106, 48'h0,              1'b0, 1'b1, 48'h0000_0000_0006, 0};
    vt[16] = '{OP_FLUSH,  32'h0,        48'h0,              1'b0, 1'b0, 48'h0, 0};
    vt[17] = '{OP_LOOKUP, 32'hC0A80105, 48'h0,              1'b0, 1'b0, 48'h0, RETRY};

    // Reset values.
    repeat (3) step();
    chk("rst_lkp_rdy", 64'(lkp_rdy), 64'(1));
    chk("rst_lkp_done", 64'(lkp_done), 64'(0));
    chk("rst_lkp_hit", 64'(lkp_hit), 64'(0));
    chk("rst_lkp_mac", 64'(lkp_mac), 64'(0));
    chk("rst_tx_en", 64'(arp_tx_en), 64'(0));
    chk("rst_tx_type", 64'(arp_tx_type), 64'(0));
    chk("rst_des_mac", 64'(des_mac), 64'(0));
    chk("rst_des_ip", 64'(des_ip), 64'(0));
    rst = 1'b0;
    step();

    // Miss on empty table, reply arrives while waiting.
    do_lookup(32'hC0A80132, 40, 48'h0011_2233_4455, h, m, ntx, lat);
    chk("reply_hit", 64'(h), 64'(1));
    chk("reply_mac", 64'(m), 64'(48'h0011_2233_4455));
    chk("reply_ntx", 64'(ntx), 64'(1));

    // Learn on the same edge that accepts the lookup is visible to the search.
    arp_rx_done = 1'b1; arp_rx_type = ARP_OP_REQ; src_ip = 32'h0A0B0C0D; src_mac = 48'hA1A2_A3A4_A5A6;
    do_lookup(32'h0A0B0C0D, -1, '0, h, m, ntx, lat);
    chk("same_cycle_hit", 64'(h), 64'(1));
    chk("same_cycle_mac", 64'(m), 64'(48'hA1A2_A3A4_A5A6));
    chk("same_cycle_lat", 64'(lat), 64'(2));

    rst = 1'b1; step(); rst = 1'b0; step();

`ifndef ARP_CACHE_AGING_EN
    foreach (vt[i]) begin
      case (vt[i].op)
        OP_LEARN: learn(vt[i].ip, vt[i].mac, vt[i].typ);
        OP_FLUSH: flush_pulse();
        default: begin
          do_lookup(vt[i].ip, -1, '0, h, m, ntx, lat);
          chk($sformatf("vec%0d_hit", i), 64'(h), 64'(vt[i].exp_hit));
          chk($sformatf("vec%0d_mac", i), 64'(m), 64'(vt[i].exp_mac));
          chk($sformatf("vec%0d_ntx", i), 64'(ntx), 64'(vt[i].exp_tx));
          if (vt[i].exp_hit) chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(2));
          else chk($sformatf("vec%0d_miss_lat_%0d", i, lat),
                   64'(lat >= RETRY * TMO && lat <= RETRY * (TMO + 4) + 4), 64'(1));
        end
      endcase
    end
`else
    learn(32'hC0A80117, 48'h2345_6789_0ABC, ARP_OP_REPLY);
    repeat (40) step();
    do_lookup(32'hC0A80117, -1, '0, h, m, ntx, lat);
    chk("aged_out_hit", 64'(h), 64'(0));
    chk("aged_out_ntx", 64'(ntx), 64'(RETRY));
    learn(32'hC0A80118, 48'h0200_0000_0001, ARP_OP_REPLY);
    for (int k = 0; k < 5; k++) begin
      repeat (18) step();
      learn(32'hC0A80118, 48'h0200_0000_0001, ARP_OP_REQ);
    end
    do_lookup(32'hC0A80118, -1, '0, h, m, ntx, lat);
    chk("refreshed_hit", 64'(h), 64'(1));
    chk("refreshed_mac", 64'(m), 64'(48'h0200_0000_0001));
    chk("refreshed_ntx", 64'(ntx), 64'(0));
`endif

    // Reset mid-lookup while a request is stalled on arp_tx_rdy.
    arp_tx_rdy = 1'b0;
    lkp_req = 1'b1; lkp_ip = 32'hC0A80163;
    step();
    lkp_req = 1'b0;
    ntx = 0;
    for (int k = 0; k < 6; k++) begin step(); if (arp_tx_en) ntx++; end
    chk("stall_no_tx", 64'(ntx), 64'(0));
    chk("stall_busy_rdy", 64'(lkp_rdy), 64'(0));
    chk("stall_des_mac", 64'(des_mac), 64'(MAC_BCAST));
    rst = 1'b1; arp_tx_rdy = 1'b1;
    step();
    rst = 1'b0;
    ntx = 0; nd = 0;
    for (int k = 0; k < 2 * TMO; k++) begin
      step();
      if (arp_tx_en) ntx++;
      if (lkp_done) nd++;
    end
    chk("rst_mid_no_tx", 64'(ntx), 64'(0));
    chk("rst_mid_no_done", 64'(nd), 64'(0));
    chk("rst_mid_rdy", 64'(lkp_rdy), 64'(1));

`ifndef ARP_CACHE_AGING_EN
    // Randomized learn/lookup traffic against the array model.
    rst = 1'b1; step(); step(); rst = 1'b0; step();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    m_rr = 0;
    for (int it = 0; it < 40; it++) begin
      rip = 32'h0A00_0001 + 32'($urandom_range(0, 5));
      if ($urandom_range(0, 9) < 5) begin
        rmac = {16'($urandom), $urandom};
        learn(rip, rmac, 1'($urandom));
        m_learn(rip, rmac);
      end else begin
        m_lookup(rip, eh, em);
        ra = -1; etx = 0;
        rmac = {16'($urandom), $urandom};
        if (!eh) begin
          if ($urandom_range(0, 1) == 1) begin
            ra = $urandom_range(1, 60);
            eh = 1'b1; em = rmac; etx = 1;
          end else begin
            etx = RETRY;
          end
        end
        do_lookup(rip, ra, rmac, h, m, ntx, lat);
        if (ra > 0) m_learn(rip, rmac);
        chk($sformatf("rnd%0d_hit", it), 64'(h), 64'(eh));
        chk($sformatf("rnd%0d_mac", it), 64'(m), 64'(em));
        chk($sformatf("rnd%0d_ntx", it), 64'(ntx), 64'(etx));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arp_cache.md
# arp_cache

Parametrised IP-to-MAC resolution cache between the ARP block and the UDP/IP transmit path. It learns bindings from every completed ARP receive, answers lookups from the IP layer, and on a miss issues an ARP request through the ARP transmit handshake, retrying until a reply is learned or retries are exhausted. It replaces the single hard-wired destination MAC/IP pair with a DEPTH-entry table.

## Interface
- DEPTH, 8: table entries, power of two, 2..32
- REQ_TIMEOUT, 125_000_000: cycles to wait for a reply after each request (1 s at 125 MHz)
- REQ_RETRY, 3: requests sent before a miss is reported
- TICK_DIV, 125_000_000: cycles per aging tick (aging build only)
- AGE_MAX, 300: ticks before an unrefreshed entry is invalidated (aging build only)

Ports:
- clk  in  1  GMII clock, 125 MHz; single clock domain
- rst  in  1  synchronous, active-high reset
- arp_rx_done  in  1  one-cycle pulse: ARP frame received
- arp_rx_type  in  1  0 = request, 1 = reply; both are learned
- src_mac  in  48  sender MAC of received frame, valid with arp_rx_done
- src_ip  in  32  sender IP of received frame, valid with arp_rx_done
- flush  in  1  one-cycle pulse: invalidate all entries
- lkp_req  in  1  lookup request, accepted when lkp_rdy = 1
- lkp_ip  in  32  IP to resolve, sampled on acceptance
- lkp_rdy  out  1  cache idle, can accept a lookup
- lkp_done  out  1  one-cycle pulse: lookup finished
- lkp_hit  out  1  valid with lkp_done: 1 = resolved
- lkp_mac  out  48  resolved MAC with lkp_done; 0 on miss
- arp_tx_rdy  in  1  ARP transmitter idle
- arp_tx_en  out  1  one-cycle pulse: send ARP frame
- arp_tx_type  out  1  always 0 (request)
- des_mac  out  48  48'hFFFF_FFFF_FFFF while requesting
- des_ip  out  32  IP being resolved

## Operation
- Table entry: valid, ip[31:0], mac[47:0], age (aging build). All entries invalid after reset or flush.
- Learn, on arp_rx_done with src_ip != 0: if an entry with matching ip exists, overwrite mac, clear age; else write lowest-index invalid entry; if full, write entry rr_ptr and increment rr_ptr mod DEPTH. src_ip == 0 (probe) is ignored.
- Lookup FSM states: IDLE, SEARCH, REQ, WAIT, DONE.
  - IDLE: lkp_rdy = 1; lkp_req registers lkp_ip -> SEARCH.
  - SEARCH: parallel compare against valid entries; hit -> DONE (hit); miss -> REQ, retry count = 0.
  - REQ: wait for arp_tx_rdy = 1, pulse arp_tx_en one cycle with des_ip = lookup IP -> WAIT, timer cleared, retry count +1.
  - WAIT: compare every cycle; match -> DONE (hit). Timer reaches REQ_TIMEOUT: retry count < REQ_RETRY -> REQ, else DONE (miss).
  - DONE: pulse lkp_done with lkp_hit/lkp_mac -> IDLE.
- flush and learn act in any FSM state; flush has priority over a same-cycle learn (learn dropped).
- Outputs are registered. Reset values: lkp_rdy 1, all other outputs 0 (des_mac 0 outside REQ/WAIT).

## Timing
- Lookup hit: lkp_done two cycles after the accepting edge.
- Learn writes at the arp_rx_done edge; visible to compare the next cycle. A learn on the same cycle as lkp_req is seen by SEARCH.
- Miss with no reply: lkp_done after REQ_RETRY x (REQ_TIMEOUT + request latency) cycles.
- lkp_req while lkp_rdy = 0 is ignored.
- rst mid-lookup: FSM to IDLE, no lkp_done, pending arp_tx_en not issued.

## Configuration
- ARP_CACHE_AGING_EN defined: prescaler counts TICK_DIV cycles; each tick increments age of every valid entry; an entry reaching AGE_MAX is invalidated that cycle; a learn on the same cycle wins (age 0, valid).
- Undefined: no age field or prescaler; entries persist until flush or replacement; TICK_DIV/AGE_MAX unused.

## Structure
- Package arp_pkg: entry struct, FSM state enum, MAC_BCAST constant, ARP_OP_REQ/ARP_OP_REPLY constants.
- Sub-module arp_cache_match: combinational IP comparator across DEPTH entries producing hit, hit index, and first-free index.

## Test plan
- Learn reply src_ip 192.168.1.23 / 23:45:67:89:0a:bc, then lookup 192.168.1.23 -> lkp_done 2 cycles later, hit 1, mac 23456789_0abc, no arp_tx_en.
- Lookup 192.168.1.50 on empty table, inject reply 1000 cycles after arp_tx_en (REQ_TIMEOUT 5000) -> one arp_tx_en, des_mac all-F, des_ip C0A80132, done hit 1.
- Same miss, no reply, REQ_TIMEOUT 100, REQ_RETRY 3 -> exactly 3 arp_tx_en pulses, then done hit 0, mac 0.
- DEPTH 4: learn 5 distinct IPs -> 5th overwrites entry 0; lookup of first IP issues a request.
- Learn existing IP with new MAC 02:00:00:00:00:01 -> no new entry, lookup returns new MAC; flush, then lookup -> miss path.
- Aging build, TICK_DIV 10, AGE_MAX 3: learn, idle 40 cycles -> entry invalid; refresh every 20 cycles -> entry stays valid.
